// File: rtl/div_seq_pkg.sv
// Shared definitions for the divider sequencer: FSM states and the
// start/annul/ready handshake levels of the iterative divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivAnnul          = 1'b1;
    localparam logic DivNoAnnul        = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_seq.sv
// EX-stage sequencer for the iterative divider: latches one DIV/DIVU,
// drives start/annul, stalls EX and holds the {hi,lo} result.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_div_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        ex_adv_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        res_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    div_state_e    r_state;
    div_state_e    w_next;
    logic [CW-1:0] r_cnt;
    logic          r_signed;
    logic [31:0]   r_op1;
    logic [31:0]   r_op2;
    logic          r_res_valid;
    logic [63:0]   r_result;

    logic w_stall;
    logic w_start;
    logic w_annul;
    logic w_take;
    logic w_capture;
    logic w_release;

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_start   = DivStop;
        w_annul   = DivNoAnnul;
        w_take    = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_stall = ex_div_valid_i & ~flush_i;
                if (w_stall) begin
                    w_take = 1'b1;
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                w_start = DivStart;
                // flush wins over a result arriving in the same cycle
                if (flush_i) begin
                    w_next = S_ABORT;
                end else if (div_ready_i == DivResultReady) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || ex_adv_i) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_ABORT: begin
                w_annul = DivAnnul;
                if (r_cnt <= CW'(1)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // drain counter: loaded on entry to ABORT, counts down to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state != S_ABORT && w_next == S_ABORT) begin
            r_cnt <= CW'(DRAIN_CYCLES);
        end else if (r_state == S_ABORT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
        end else if (w_take) begin
            r_signed <= ex_div_signed_i;
            r_op1    <= ex_op1_i;
            r_op2    <= ex_op2_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_result    <= div_result_i;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
            r_result    <= '0;
        end
    end

    // gated so every output reads 0 while reset is held
    assign stallreq_o   = w_stall & rst;
    assign div_start_o  = w_start;
    assign div_annul_o  = w_annul;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign res_valid_o  = r_res_valid;
    assign hi_o         = r_result[63:32];
    assign lo_o         = r_result[31:0];

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: behavioural divider stub with variable latency,
// directed handshake/flush/reset cases and randomized divisions.
module tb_div_seq;

    localparam int DRAIN = 2;

    logic        clk;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_div_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        ex_adv_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] d_result;
    logic        d_ready;
    logic        res_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_chk = 0;
    int n_err = 0;
    int unsigned lat = 35;
    int unsigned dcnt;

    div_seq #(.DRAIN_CYCLES(DRAIN)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ex_div_valid_i  (ex_div_valid_i),
        .ex_div_signed_i (ex_div_signed_i),
        .ex_op1_i        (ex_op1_i),
        .ex_op2_i        (ex_op2_i),
        .ex_adv_i        (ex_adv_i),
        .flush_i         (flush_i),
        .stallreq_o      (stallreq_o),
        .div_start_o     (div_start_o),
        .div_annul_o     (div_annul_o),
        .div_signed_o    (div_signed_o),
        .div_op1_o       (div_op1_o),
        .div_op2_o       (div_op2_o),
        .div_result_i    (d_result),
        .div_ready_i     (d_ready),
        .res_valid_o     (res_valid_o),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {remainder, quotient}; zero divisor yields zero
    function automatic logic [63:0] ref_div(input logic sgn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // divider stub: ready after lat cycles of start, dropped when start falls
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_ready  <= 1'b0;
            d_result <= '0;
            dcnt     <= 0;
        end else if (div_annul_o || !div_start_o) begin
            d_ready  <= 1'b0;
            d_result <= '0;
            dcnt     <= 0;
        end else if (!d_ready) begin
            if (dcnt + 1 >= lat) begin
                d_ready  <= 1'b1;
                d_result <= ref_div(div_signed_o, div_op1_o, div_op2_o);
            end
            dcnt <= dcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic request(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int latency);
        @(negedge clk);
        lat             = latency;
        ex_div_valid_i  = 1'b1;
        ex_div_signed_i = sgn;
        ex_op1_i        = a;
        ex_op2_i        = b;
        #1 chk("stall_on_req", stallreq_o, 1);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int hold, input int latency,
                           input logic flush_exit);
        logic ok = 1'b1;
        logic ok2 = 1'b1;
        logic got = 1'b0;
        request(sgn, a, b, latency);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (res_valid_o) got = 1'b1;
            else if (!(div_start_o && stallreq_o && !div_annul_o &&
                       div_op1_o == a && div_op2_o == b &&
                       div_signed_o == sgn)) ok = 1'b0;
        end
        chk("busy_phase", ok, 1);
        chk("done_seen", got, 1);
        chk("result", {hi_o, lo_o}, exp);
        chk("done_start_stall", {div_start_o, stallreq_o}, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!(res_valid_o && {hi_o, lo_o} == exp &&
                  !div_start_o && !stallreq_o)) ok2 = 1'b0;
        end
        if (hold > 0) chk("done_hold", ok2, 1);
        if (flush_exit) flush_i = 1'b1;
        else ex_adv_i = 1'b1;
        @(negedge clk);
        ex_adv_i       = 1'b0;
        flush_i        = 1'b0;
        ex_div_valid_i = 1'b0;
        chk("cleared", {res_valid_o, hi_o, lo_o}, 0);
        chk("ready_fall", d_ready, 0);
    endtask

    // after < 0: flush in the very cycle the divider reports ready
    task automatic run_abort(input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input int after,
                             input int latency);
        int n = 0;
        logic bad = 1'b0;
        request(sgn, a, b, latency);
        if (after < 0) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (d_ready) break;
            end
            chk("ready_before_flush", {d_ready, div_start_o}, 2'b11);
        end else begin
            repeat (after) @(negedge clk);
            chk("busy_before_flush", div_start_o, 1);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i        = 1'b0;
        ex_div_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!div_annul_o) break;
            n++;
            if (res_valid_o || div_start_o || stallreq_o) bad = 1'b1;
            @(negedge clk);
        end
        chk("annul_cycles", n, DRAIN);
        chk("abort_quiet", bad, 0);
        chk("drain_ready_low", d_ready, 0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        rst             = 1'b0;
        ex_div_valid_i  = 1'b0;
        ex_div_signed_i = 1'b0;
        ex_op1_i        = '0;
        ex_op2_i        = '0;
        ex_adv_i        = 1'b0;
        flush_i         = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", {stallreq_o, div_start_o, div_annul_o,
                           div_signed_o, res_valid_o}, 0);
        chk("reset_ops", {div_op1_o, div_op2_o}, 0);
        chk("reset_res", {hi_o, lo_o}, 0);

        run_div(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 35, 0);
        run_div(0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 35, 0);

        run_abort(0, 32'd1000, 32'd3, 10, 35);
        run_div(0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 35, 0);

        run_abort(0, 32'd55, 32'd0, 1, 35);
        run_div(1, 32'd77, 32'hFFFFFFF5, {32'd0, 32'hFFFFFFF9}, 0, 35, 0);

        run_abort(1, 32'd12, 32'd5, -1, 3);
        run_div(0, 32'd12, 32'd5, {32'd2, 32'd2}, 0, 3, 0);

        run_div(0, 32'd50, 32'd8, {32'd2, 32'd6}, 5, 4, 0);
        run_div(0, 32'd17, 32'd0, 64'd0, 1, 1, 1);

        @(negedge clk);
        ex_div_valid_i = 1'b1;
        flush_i        = 1'b1;
        #1 chk("idle_flush_stall", stallreq_o, 0);
        @(negedge clk);
        chk("idle_flush_start", div_start_o, 0);
        ex_div_valid_i = 1'b0;
        flush_i        = 1'b0;

        request(0, 32'd1234, 32'd5, 35);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_ctrl", {stallreq_o, div_start_o, div_annul_o,
                         div_signed_o, res_valid_o}, 0);
        chk("rst_ops", {div_op1_o, div_op2_o}, 0);
        chk("rst_res", {hi_o, lo_o}, 0);
        ex_div_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div(0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 0, 5, 0);

        for (int k = 0; k < 16; k++) begin
            sgn = 1'($urandom % 2);
            a   = $urandom;
            if ($urandom % 5 == 0) b = 32'd0;
            else if ($urandom % 2 == 0) b = $urandom;
            else b = $urandom_range(1, 100) * ((sgn && $urandom % 2 == 0) ?
                                               32'hFFFFFFFF : 32'd1);
            if ($urandom % 4 == 0)
                run_abort(sgn, a, b, $urandom_range(1, 5), 40);
            else
                run_div(sgn, a, b, ref_div(sgn, a, b),
                        $urandom_range(0, 3), $urandom_range(1, 40),
                        1'($urandom % 4 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequencer between the EX stage and the iterative 32-bit divider. It accepts one DIV/DIVU per request, latches the operands, and drives the divider's start/annul handshake. It also raises the EX stall request and presents the 64-bit {remainder, quotient} result for the HI/LO write path. On a pipeline flush it aborts or drains the divider cleanly, so the next division always starts from the divider's free state.

## Interface
Parameters:
- DRAIN_CYCLES, 2: cycles of start=0/annul=1 held after an abort; must cover divider ByZero→End→Free.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_div_valid_i  in  1  EX holds a DIV/DIVU needing the divider
- ex_div_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_op1_i  in  32  dividend
- ex_op2_i  in  32  divisor
- ex_adv_i  in  1  the EX instruction leaves EX this cycle
- flush_i  in  1  exception/branch flush of EX
- stallreq_o  out  1  EX stall request
- div_start_o  out  1  divider start
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  latched signed flag
- div_op1_o  out  32  latched dividend
- div_op2_o  out  32  latched divisor
- div_result_i  in  64  divider result: [63:32] remainder, [31:0] quotient
- div_ready_i  in  1  divider result ready
- res_valid_o  out  1  hi_o/lo_o valid for the EX instruction
- hi_o  out  32  remainder
- lo_o  out  32  quotient

## Operation
- Reset: state IDLE, drain counter 0. All outputs are 0.
- The latched operands and signed flag stay constant from the start cycle until the sequencer returns to IDLE. The divider re-reads them in its final fixup cycle.
- IDLE:
  - stallreq_o = ex_div_valid_i & ~flush_i.
  - If ex_div_valid_i & ~flush_i, latch the operands and the signed flag, then go to BUSY.
  - If flush_i is high, the request is ignored.
- BUSY:
  - div_start_o = 1 and stallreq_o = 1.
  - If flush_i, go to ABORT; flush has priority over div_ready_i in the same cycle.
  - Else, if div_ready_i, register div_result_i into hi_o/lo_o, set res_valid_o, and go to DONE.
- DONE:
  - div_start_o = 0, which returns the divider to Free. stallreq_o = 0. res_valid_o = 1 with the result held.
  - If flush_i, clear res_valid_o and go to IDLE.
  - Else, if ex_adv_i, go to IDLE. The result stays visible through the ex_adv_i cycle and is cleared the next cycle.
  - ex_div_valid_i is ignored in DONE, so the same instruction is never restarted.
- ABORT:
  - div_start_o = 0, div_annul_o = 1, stallreq_o = 0, res_valid_o = 0.
  - Load the counter with DRAIN_CYCLES on entry and decrement it each cycle. Go to IDLE when it reaches 0.
  - div_ready_i is ignored in ABORT.
- Divide-by-zero: no special case. The divider returns a zero result, which is delivered normally.
- Asserting rst mid-operation returns the block to IDLE immediately with all outputs 0. The divider shares the same reset.

## Timing
- Start to ready latency is set by the divider, nominally 35 cycles. Any latency of 1 or more cycles must work.
- The result is registered, so res_valid_o rises the cycle after div_ready_i is sampled high.
- stallreq_o rises in the same cycle ex_div_valid_i rises (combinational in IDLE). It falls in the first DONE cycle.
- Minimum request-to-request spacing: BUSY → DONE → IDLE. A new start can issue in the cycle after ex_adv_i.
- Abort costs DRAIN_CYCLES + 1 cycles from flush until IDLE.

## Structure
- State encodings (IDLE/BUSY/DONE/ABORT) go in the shared defines header, next to the existing Div* constants. The divider handshake constants are reused from there.
- No sub-module. The divider is instantiated beside this block by the EX-stage parent. The sequencer is a single FSM plus a drain counter and result register.

## Test plan
- Signed DIV, op1=0xFFFFFFF9 (−7), op2=2 → res_valid_o with lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. stallreq_o high from the request until DONE.
- DIVU, op1=100, op2=7 → lo_o=14, hi_o=2. Checks: one start pulse train; start drops in DONE; divider ready falls the following cycle.
- flush_i 10 cycles after the start → ABORT with annul=1 for 2 cycles, no res_valid_o. An immediately following DIVU 9/3 then gives lo_o=3, hi_o=0.
- op2=0 then flush one cycle after start (divider in ByZero) → drain reaches IDLE with divider ready low. The next division is correct.
- ex_adv_i held low for 5 cycles in DONE → result held stable, no restart, stallreq_o low. Cleared the cycle after ex_adv_i.
- rst asserted in mid-BUSY → all outputs 0 asynchronously. After release, DIVU 0xFFFFFFFF/0x10 gives lo_o=0x0FFFFFFF, hi_o=0xF.
